// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD registered read ports with write-through bypass,
// two prioritised write ports, per-register busy scoreboard and optional zero register 0.
module reg_file_mp #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned NUM_RD    = 3,
    parameter bit          ZERO_REG0 = 1'b0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    input  logic [NUM_RD-1:0]          i_rd_en,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    input  logic                       i_wr0_en,
    input  logic [ADDR_W-1:0]          i_wr0_addr,
    input  logic [DATA_W-1:0]          i_wr0_data,
    input  logic                       i_wr1_en,
    input  logic [ADDR_W-1:0]          i_wr1_addr,
    input  logic [DATA_W-1:0]          i_wr1_data,
    input  logic                       i_issue_en,
    input  logic [ADDR_W-1:0]          i_issue_addr,
    output logic [(2**ADDR_W)-1:0]     o_busy
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]        r_regs     [NUM_REGS];
    logic [DATA_W-1:0]        w_regs_nxt [NUM_REGS];
    logic [NUM_REGS-1:0]      r_busy;
    logic [NUM_REGS-1:0]      w_busy_nxt;
    logic [NUM_RD*DATA_W-1:0] r_rd_data;
    logic                     w_wr0_ok;
    logic                     w_wr1_ok;
    logic                     w_issue_ok;

    // Register 0 swallows writes and issues when it is hardwired to zero
    always_comb begin
        w_wr0_ok   = i_wr0_en   && !(ZERO_REG0 && (i_wr0_addr   == '0));
        w_wr1_ok   = i_wr1_en   && !(ZERO_REG0 && (i_wr1_addr   == '0));
        w_issue_ok = i_issue_en && !(ZERO_REG0 && (i_issue_addr == '0));
    end

    // Post-edge view of storage and busy; wr1 overrides wr0, issue overrides writeback
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_regs_nxt[r] = r_regs[r];
            w_busy_nxt[r] = r_busy[r];
            if (w_wr0_ok && (i_wr0_addr == ADDR_W'(r))) begin
                w_regs_nxt[r] = i_wr0_data;
                w_busy_nxt[r] = 1'b0;
            end
            if (w_wr1_ok && (i_wr1_addr == ADDR_W'(r))) begin
                w_regs_nxt[r] = i_wr1_data;
                w_busy_nxt[r] = 1'b0;
            end
            if (w_issue_ok && (i_issue_addr == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= w_regs_nxt[r];
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports sample the post-write value, giving same-edge bypass
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if (i_rd_en[i]) begin
                    r_rd_data[i*DATA_W +: DATA_W] <= w_regs_nxt[i_rd_addr[i*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default and zero-register builds driven in lockstep, each cycle's
// expected outputs queued by the stimulus and checked by an independent monitor.
module tb_reg_file_mp;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned NR   = 3;
    localparam int unsigned NREG = 16;

    typedef struct packed {
        logic [1:0][NR-1:0][DW-1:0] rd;
        logic [1:0][NREG-1:0]       bsy;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic [NR*AW-1:0]    rd_addr;
    logic [NR-1:0]       rd_en;
    logic                wr0_en, wr1_en, issue_en;
    logic [AW-1:0]       wr0_addr, wr1_addr, issue_addr;
    logic [DW-1:0]       wr0_data, wr1_data;
    logic [1:0][NR*DW-1:0] rd_data;
    logic [1:0][NREG-1:0]  busy;

    int vectors     = 0;
    int miscompares = 0;
    exp_t sb[$];

    logic [DW-1:0]   m_mem  [2][NREG];
    logic [NREG-1:0] m_busy [2];
    logic [DW-1:0]   m_rd   [2][NR];

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG0(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .i_rd_en(rd_en),
        .o_rd_data(rd_data[0]), .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr),
        .i_wr0_data(wr0_data), .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr),
        .i_wr1_data(wr1_data), .i_issue_en(issue_en), .i_issue_addr(issue_addr),
        .o_busy(busy[0])
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG0(1'b1)) dut_z (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .i_rd_en(rd_en),
        .o_rd_data(rd_data[1]), .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr),
        .i_wr0_data(wr0_data), .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr),
        .i_wr1_data(wr1_data), .i_issue_en(issue_en), .i_issue_addr(issue_addr),
        .o_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        rd_en    = '0;
        rd_addr  = '0;
        wr0_en   = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en   = 1'b0; wr1_addr = '0; wr1_data = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int r = 0; r < NREG; r++) m_mem[z][r] = '0;
            for (int p = 0; p < NR; p++) m_rd[z][p] = '0;
            m_busy[z] = '0;
        end
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    // Apply current inputs for one edge: predict both builds, queue the expectation, advance
    task automatic tick();
        exp_t e;
        for (int z = 0; z < 2; z++) begin
            logic [DW-1:0] nm [NREG];
            for (int r = 0; r < NREG; r++) nm[r] = m_mem[z][r];
            if (wr0_en) nm[wr0_addr] = wr0_data;
            if (wr1_en) nm[wr1_addr] = wr1_data;
            if (z == 1) nm[0] = '0;
            if (wr0_en)   m_busy[z][wr0_addr]   = 1'b0;
            if (wr1_en)   m_busy[z][wr1_addr]   = 1'b0;
            if (issue_en) m_busy[z][issue_addr] = 1'b1;
            if (z == 1)   m_busy[z][0] = 1'b0;
            for (int p = 0; p < NR; p++) begin
                if (rd_en[p]) m_rd[z][p] = nm[rd_addr[p*AW +: AW]];
                e.rd[z][p] = m_rd[z][p];
            end
            for (int r = 0; r < NREG; r++) m_mem[z][r] = nm[r];
            e.bsy[z] = m_busy[z];
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic chk_all_zero(input string tag);
        for (int z = 0; z < 2; z++) begin
            for (int p = 0; p < NR; p++)
                chk($sformatf("%s_rd%0d_b%0d", tag, p, z), rd_data[z][p*DW +: DW], '0);
            chk($sformatf("%s_busy_b%0d", tag, z), DW'(busy[z]), '0);
        end
    endtask

    // Monitor: every edge that has a queued expectation is compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int z = 0; z < 2; z++) begin
                    for (int p = 0; p < NR; p++)
                        chk($sformatf("rd%0d_b%0d", p, z), rd_data[z][p*DW +: DW], e.rd[z][p]);
                    chk($sformatf("busy_b%0d", z), DW'(busy[z]), DW'(e.bsy[z]));
                end
            end
        end
    end

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        // Writes attempted while reset is held must not land
        wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'h1234_5678;
        issue_en = 1'b1; issue_addr = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        for (int a = 0; a < NREG; a++) begin
            set_rd(0, AW'(a));
            tick();
        end

        wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'h0000_00AA;
        set_rd(1, 4'd5);
        tick();
        set_rd(2, 4'd5);
        tick();

        wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 4'd3; wr1_data = 32'h22;
        set_rd(0, 4'd3);
        tick();
        set_rd(1, 4'd3);
        tick();

        issue_en = 1'b1; issue_addr = 4'd7;
        tick();
        tick();
        wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 32'h77;
        tick();
        issue_en = 1'b1; issue_addr = 4'd7;
        wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'h78;
        tick();

        wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 32'hDEAD_BEEF;
        issue_en = 1'b1; issue_addr = 4'd0;
        tick();
        set_rd(2, 4'd0);
        tick();

        for (int n = 0; n < 400; n++) begin
            rd_en = NR'($urandom);
            for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom);
            wr0_en = 1'($urandom); wr1_en = 1'($urandom); issue_en = 1'($urandom_range(0, 3) == 0);
            wr0_addr   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr1_addr   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            issue_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr0_data = $urandom; wr1_data = $urandom;
            tick();
        end

        wr1_en = 1'b1; wr1_addr = 4'd9; wr1_data = 32'h55;
        issue_en = 1'b1; issue_addr = 4'd9;
        tick();
        set_rd(0, 4'd9);
        tick();
        repeat (3) tick();

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_rd(0, 4'd9);
        tick();
        tick();

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", DW'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
